xt_hb_rr_arbiter: RTL and testbench
===================================

XT_HB_RR_ARBITER -- requirements
Module: xt_hb_rr_arbiter

Interface
REQ-001 SHALL have parameter MASTER_NUM, default 2, number of high-speed-bus masters, legal 1..8.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum HOLD cycles per grant, legal 2..65535.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port read_req  input  MASTER_NUM  per-master read request; bit i is master i.
REQ-006 SHALL have port write_req  input  MASTER_NUM  per-master write request.
REQ-007 SHALL have port read_done  input  1  granted read completes this cycle (bus read not stalled).
REQ-008 SHALL have port write_done  input  1  granted write completes this cycle.
REQ-009 SHALL have port read_grant  output  MASTER_NUM  one-hot-or-zero read-channel grant.
REQ-010 SHALL have port write_grant  output  MASTER_NUM  one-hot-or-zero write-channel grant.
REQ-011 SHALL have port read_busy  output  1  read channel held by a master.
REQ-012 SHALL have port write_busy  output  1  write channel held by a master.
REQ-013 SHALL have port read_timeout  output  1  one-cycle pulse; read hold aborted.
REQ-014 SHALL have port write_timeout  output  1  one-cycle pulse; write hold aborted.
REQ-015 SHALL have port timeout_id  output  3  index of the master aborted by the most recent timeout.

Function
REQ-016 Read and write channels SHALL be two independent identical instances of the channel logic below (full duplex); one master may hold both channels at once.
REQ-017 Each channel SHALL have states IDLE and HOLD, plus an owner register, a last-winner pointer and a hold counter, width ceil(log2(TIMEOUT_CYCLES+1)).
REQ-018 IDLE, no request: grant = 0, busy = 0.
REQ-019 IDLE, any request: grant SHALL be the one-hot winner combinationally in the same cycle (zero latency). Search order is last+1, last+2, ... wrapping modulo MASTER_NUM.
REQ-020 IDLE with grant and done in the same cycle: stay IDLE; last <= winner.
REQ-021 IDLE with grant and no done: go to HOLD; owner <= winner; last <= winner; counter <= 1.
REQ-022 HOLD: grant = one-hot(owner) regardless of other requests; busy = 1.
REQ-023 HOLD with done: go to IDLE next cycle. A different requester SHALL NOT be granted in the done cycle.
REQ-024 HOLD with the owner's req low: release to IDLE next cycle, grant = 0 in that cycle (requester abandoned).
REQ-025 HOLD with counter == TIMEOUT_CYCLES and no done: go to IDLE; pulse *_timeout for 1 cycle; timeout_id <= owner; last <= MASTER_NUM-1, so master 0 has top priority next.
REQ-026 Done has priority over timeout when both occur in the same cycle; no pulse.
REQ-027 Otherwise in HOLD: counter increments by 1 and SHALL saturate, never wrap.
REQ-028 Simultaneous read and write timeouts: both pulses assert; timeout_id takes the write owner.
REQ-029 Grant outputs SHALL never have more than one bit set; there SHALL be no grant to a master whose req is low.
REQ-030 MASTER_NUM == 1: master 0 is always the winner; the pointer is constant 0.

Reset
REQ-031 While rst_n is low: both channels IDLE; owner = 0; last = MASTER_NUM-1; counters = 0; timeout pulses = 0; timeout_id = 0. In-flight holds are dropped immediately.
REQ-032 After rst_n rises, the first request SHALL be arbitrated with master 0 as highest priority.
REQ-033 Grant outputs SHALL be 0 during reset even if requests are high.

Verification
REQ-034 Reset; read_req=2'b11 held, read_done=1 every cycle -> read_grant sequence 01,10,01,10.
REQ-035 read_req=01 and read_done=0 for 3 cycles; then read_req=11, read_done=1 -> grant stays 01 for 4 cycles; cycle 5 IDLE picks 10.
REQ-036 TIMEOUT_CYCLES=4, write_req=10 held, write_done=0 -> write_grant=10 for 4 cycles; write_timeout pulses once; timeout_id=1; next grant with write_req=11 is 01.
REQ-037 Master 0 holds read, master 1 requests write simultaneously -> read_grant=01 and write_grant=10 in the same cycle; both busy.
REQ-038 rst_n dropped mid-HOLD -> grants 0 asynchronously; after release, request 11 grants 01.
REQ-039 Done and counter==TIMEOUT_CYCLES in the same cycle -> no timeout pulse; IDLE; pointer = owner.

Source files
------------

// File: rtl/xt_hb_rr_arbiter.sv
// xt_hb_rr_arbiter: full-duplex round-robin bus arbiter
// with independent read/write channels and hold timeout.
module xt_hb_rr_channel #(
  parameter int N = 2,
  parameter int T = 255
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N-1:0]                        req,
  input  logic                                done,
  output logic [N-1:0]                        grant,
  output logic                                busy,
  output logic                                abort,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] owner
);
  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(T + 1);
  localparam logic [CW-1:0] LIM = CW'(T);
  localparam logic [LW-1:0] TOP = LW'(N - 1);

  typedef enum logic {IDLE, HOLD} st_t;

  st_t           st, st_nxt;
  logic [LW-1:0] last, last_nxt, owner_nxt, win;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [N-1:0]  win_oh, own_oh;
  logic          any, own_req, at_lim;
  int            d, best;

  // winner = requester at the smallest rotating distance past last
  always_comb begin
    win  = '0;
    any  = 1'b0;
    best = N;
    d    = 0;
    for (int m = 0; m < N; m++) begin
      d = m - int'(last) - 1;
      if (d < 0) d = d + N;
      if (req[m] && d < best) begin
        best = d;
        win  = LW'(m);
        any  = 1'b1;
      end
    end
  end

  assign win_oh  = N'(1) << win;
  assign own_oh  = N'(1) << owner;
  assign own_req = |(req & own_oh);
  assign at_lim  = (cnt == LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= IDLE;
      owner <= '0;
      last  <= TOP;
      cnt   <= '0;
    end else begin
      st    <= st_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    st_nxt    = st;
    last_nxt  = last;
    owner_nxt = owner;
    cnt_nxt   = cnt;
    unique case (st)
      IDLE: begin
        if (any) begin
          last_nxt = win;
          if (!done) begin
            st_nxt    = HOLD;
            owner_nxt = win;
            cnt_nxt   = CW'(1);
          end
        end
      end
      HOLD: begin
        if (done || !own_req) begin
          st_nxt = IDLE;
        end else if (at_lim) begin
          st_nxt   = IDLE;
          last_nxt = TOP;
        end else if (cnt != '1) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    endcase
  end

  // the aborting cycle withdraws the grant unless the transfer completes
  always_comb begin
    grant = '0;
    busy  = 1'b0;
    abort = 1'b0;
    if (rst_n) begin
      unique case (st)
        IDLE: grant = any ? win_oh : '0;
        HOLD: begin
          busy  = 1'b1;
          grant = (own_req && (done || !at_lim)) ? own_oh : '0;
          abort = own_req && !done && at_lim;
        end
      endcase
    end
  end
endmodule

module xt_hb_rr_arbiter #(
  parameter int MASTER_NUM     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [MASTER_NUM-1:0] read_req,
  input  logic [MASTER_NUM-1:0] write_req,
  input  logic                  read_done,
  input  logic                  write_done,
  output logic [MASTER_NUM-1:0] read_grant,
  output logic [MASTER_NUM-1:0] write_grant,
  output logic                  read_busy,
  output logic                  write_busy,
  output logic                  read_timeout,
  output logic                  write_timeout,
  output logic [2:0]            timeout_id
);
  localparam int LW = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;

  logic [LW-1:0] rd_owner, wr_owner;
  logic          rd_abort, wr_abort;

  xt_hb_rr_channel #(
    .N (MASTER_NUM),
    .T (TIMEOUT_CYCLES)
  ) u_rd (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (read_req),
    .done  (read_done),
    .grant (read_grant),
    .busy  (read_busy),
    .abort (rd_abort),
    .owner (rd_owner)
  );

  xt_hb_rr_channel #(
    .N (MASTER_NUM),
    .T (TIMEOUT_CYCLES)
  ) u_wr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (write_req),
    .done  (write_done),
    .grant (write_grant),
    .busy  (write_busy),
    .abort (wr_abort),
    .owner (wr_owner)
  );

  // write owner wins the id when both channels abort together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_timeout  <= 1'b0;
      write_timeout <= 1'b0;
      timeout_id    <= 3'd0;
    end else begin
      read_timeout  <= rd_abort;
      write_timeout <= wr_abort;
      if (wr_abort)
        timeout_id <= 3'(wr_owner);
      else if (rd_abort)
        timeout_id <= 3'(rd_owner);
    end
  end
endmodule

// File: tb/tb_xt_hb_rr_arbiter.sv
// tb_xt_hb_rr_arbiter: directed vector table plus randomized
// comparison against a behavioural round-robin model.
module tb_xt_hb_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] a_rr, a_wr, a_rg, a_wg;
  logic       a_rd, a_wd, a_rb, a_wb, a_rt, a_wt;
  logic [2:0] a_id;

  logic [4:0] b_rr, b_wr, b_rg, b_wg;
  logic       b_rd, b_wd, b_rb, b_wb, b_rt, b_wt;
  logic [2:0] b_id;

  xt_hb_rr_arbiter #(.MASTER_NUM(2), .TIMEOUT_CYCLES(4)) u_a (
    .clk(clk), .rst_n(rst_n),
    .read_req(a_rr), .write_req(a_wr),
    .read_done(a_rd), .write_done(a_wd),
    .read_grant(a_rg), .write_grant(a_wg),
    .read_busy(a_rb), .write_busy(a_wb),
    .read_timeout(a_rt), .write_timeout(a_wt),
    .timeout_id(a_id)
  );

  xt_hb_rr_arbiter #(.MASTER_NUM(5), .TIMEOUT_CYCLES(6)) u_b (
    .clk(clk), .rst_n(rst_n),
    .read_req(b_rr), .write_req(b_wr),
    .read_done(b_rd), .write_done(b_wd),
    .read_grant(b_rg), .write_grant(b_wg),
    .read_busy(b_rb), .write_busy(b_wb),
    .read_timeout(b_rt), .write_timeout(b_wt),
    .timeout_id(b_id)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int cyc, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] rr, wr;
    logic       rd, wd;
    logic [1:0] rg, wg;
    logic       rb, wb, rt, wt;
    logic [2:0] id;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic [1:0] rr, input logic [1:0] wr,
                     input logic rd, input logic wd,
                     input logic [1:0] rg, input logic [1:0] wg,
                     input logic rb, input logic wb,
                     input logic rt, input logic wt, input logic [2:0] id);
    vec_t v;
    v.rr = rr; v.wr = wr; v.rd = rd; v.wd = wd;
    v.rg = rg; v.wg = wg; v.rb = rb; v.wb = wb;
    v.rt = rt; v.wt = wt; v.id = id;
    tv.push_back(v);
  endtask

  typedef struct {
    bit hold;
    int owner;
    int last;
    int cnt;
  } ch_t;

  function automatic ch_t ch_reset(input int n);
    ch_t s;
    s.hold = 1'b0; s.owner = 0; s.last = n - 1; s.cnt = 0;
    return s;
  endfunction

  function automatic void ch_step(input ch_t s, input bit [7:0] req,
      input bit done, input int n, input int t,
      output ch_t ns, output bit [7:0] g, output bit busy, output bit ab);
    bit found;
    int m;
    ns = s; g = '0; busy = s.hold; ab = 1'b0; found = 1'b0; m = 0;
    if (!s.hold) begin
      for (int k = 1; k <= n; k++) begin
        m = (s.last + k) % n;
        if (!found && req[m]) begin
          found = 1'b1;
          g[m] = 1'b1;
          ns.last = m;
          if (!done) begin
            ns.hold = 1'b1; ns.owner = m; ns.cnt = 1;
          end
        end
      end
    end else if (!req[s.owner]) begin
      ns.hold = 1'b0;
    end else if (done) begin
      g[s.owner] = 1'b1;
      ns.hold = 1'b0;
    end else if (s.cnt >= t) begin
      ns.hold = 1'b0;
      ab = 1'b1;
      ns.last = n - 1;
    end else begin
      g[s.owner] = 1'b1;
      ns.cnt = s.cnt + 1;
    end
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=-1 act=0 exp=1");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ch_t mar, maw, mbr, mbw, nr, nw;
    bit [7:0] gr, gw;
    bit br, bw, abr, abw;
    int ea_rt, ea_wt, ea_id, eb_rt, eb_wt, eb_id;

    a_rr = 2'b11; a_wr = 2'b11; a_rd = 1'b0; a_wd = 1'b0;
    b_rr = 5'h1f; b_wr = 5'h1f; b_rd = 1'b0; b_wd = 1'b0;
    #1;
    chk("rst.rg", -1, a_rg, 0);
    chk("rst.wg", -1, a_wg, 0);
    chk("rst.rb", -1, a_rb, 0);
    chk("rst.bg", -1, b_rg, 0);
    chk("rst.to", -1, {a_rt, a_wt}, 0);
    chk("rst.id", -1, a_id, 0);
    @(negedge clk);
    @(negedge clk);
    a_rr = '0; a_wr = '0; b_rr = '0; b_wr = '0;
    rst_n = 1'b1;

    // rr wr rd wd | rg wg rb wb rt wt id
    add(2'b11, 2'b00, 1, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0);
    add(2'b11, 2'b00, 1, 0, 2'b10, 2'b00, 0, 0, 0, 0, 0);
    add(2'b11, 2'b00, 1, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0);
    add(2'b11, 2'b00, 1, 0, 2'b10, 2'b00, 0, 0, 0, 0, 0);
    add(2'b01, 2'b00, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0);
    add(2'b01, 2'b00, 0, 0, 2'b01, 2'b00, 1, 0, 0, 0, 0);
    add(2'b01, 2'b00, 0, 0, 2'b01, 2'b00, 1, 0, 0, 0, 0);
    add(2'b11, 2'b00, 1, 0, 2'b01, 2'b00, 1, 0, 0, 0, 0);
    add(2'b11, 2'b00, 1, 0, 2'b10, 2'b00, 0, 0, 0, 0, 0);
    add(2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    add(2'b00, 2'b10, 0, 0, 2'b00, 2'b10, 0, 0, 0, 0, 0);
    add(2'b00, 2'b10, 0, 0, 2'b00, 2'b10, 0, 1, 0, 0, 0);
    add(2'b00, 2'b10, 0, 0, 2'b00, 2'b10, 0, 1, 0, 0, 0);
    add(2'b00, 2'b10, 0, 0, 2'b00, 2'b10, 0, 1, 0, 0, 0);
    add(2'b00, 2'b10, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0, 0);
    add(2'b00, 2'b11, 0, 1, 2'b00, 2'b01, 0, 0, 0, 1, 1);
    add(2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1);
    add(2'b01, 2'b10, 0, 0, 2'b01, 2'b10, 0, 0, 0, 0, 1);
    add(2'b01, 2'b10, 0, 0, 2'b01, 2'b10, 1, 1, 0, 0, 1);
    add(2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 1, 1, 0, 0, 1);
    add(2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1);
    add(2'b01, 2'b00, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 1);
    add(2'b01, 2'b00, 0, 0, 2'b01, 2'b00, 1, 0, 0, 0, 1);
    add(2'b01, 2'b00, 0, 0, 2'b01, 2'b00, 1, 0, 0, 0, 1);
    add(2'b01, 2'b00, 0, 0, 2'b01, 2'b00, 1, 0, 0, 0, 1);
    add(2'b01, 2'b00, 1, 0, 2'b01, 2'b00, 1, 0, 0, 0, 1);
    add(2'b11, 2'b00, 1, 0, 2'b10, 2'b00, 0, 0, 0, 0, 1);
    add(2'b01, 2'b10, 0, 0, 2'b01, 2'b10, 0, 0, 0, 0, 1);
    add(2'b01, 2'b10, 0, 0, 2'b01, 2'b10, 1, 1, 0, 0, 1);
    add(2'b01, 2'b10, 0, 0, 2'b01, 2'b10, 1, 1, 0, 0, 1);
    add(2'b01, 2'b10, 0, 0, 2'b01, 2'b10, 1, 1, 0, 0, 1);
    add(2'b01, 2'b10, 0, 0, 2'b00, 2'b00, 1, 1, 0, 0, 1);
    add(2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1, 1);
    add(2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1);

    foreach (tv[i]) begin
      @(negedge clk);
      a_rr = tv[i].rr; a_wr = tv[i].wr;
      a_rd = tv[i].rd; a_wd = tv[i].wd;
      #1;
      chk("vec.rg", i, a_rg, tv[i].rg);
      chk("vec.wg", i, a_wg, tv[i].wg);
      chk("vec.busy", i, {a_rb, a_wb}, {tv[i].rb, tv[i].wb});
      chk("vec.to", i, {a_rt, a_wt}, {tv[i].rt, tv[i].wt});
      chk("vec.id", i, a_id, tv[i].id);
    end

    // asynchronous reset in the middle of a read hold
    @(negedge clk);
    a_rr = 2'b01; a_rd = 1'b0; a_wr = 2'b00; a_wd = 1'b0;
    #1 chk("ar.g0", -1, a_rg, 2'b01);
    @(negedge clk);
    #1 chk("ar.hold", -1, {a_rg, a_rb}, {2'b01, 1'b1});
    #1 rst_n = 1'b0;
    #1 chk("ar.gz", -1, a_rg, 0);
    chk("ar.bz", -1, a_rb, 0);
    chk("ar.idz", -1, a_id, 0);
    @(negedge clk);
    rst_n = 1'b1; a_rr = 2'b11; a_rd = 1'b1;
    #1 chk("ar.first", -1, a_rg, 2'b01);

    // randomized phase against the model
    @(negedge clk);
    rst_n = 1'b0;
    a_rr = '0; a_wr = '0; b_rr = '0; b_wr = '0;
    a_rd = 0; a_wd = 0; b_rd = 0; b_wd = 0;
    @(negedge clk);
    rst_n = 1'b1;
    mar = ch_reset(2); maw = ch_reset(2);
    mbr = ch_reset(5); mbw = ch_reset(5);
    ea_rt = 0; ea_wt = 0; ea_id = 0;
    eb_rt = 0; eb_wt = 0; eb_id = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(0, 7) == 0) a_rr[m] = ~a_rr[m];
        if ($urandom_range(0, 7) == 0) a_wr[m] = ~a_wr[m];
      end
      for (int m = 0; m < 5; m++) begin
        if ($urandom_range(0, 9) == 0) b_rr[m] = ~b_rr[m];
        if ($urandom_range(0, 9) == 0) b_wr[m] = ~b_wr[m];
      end
      a_rd = ($urandom_range(0, 5) == 0);
      a_wd = ($urandom_range(0, 5) == 0);
      b_rd = ($urandom_range(0, 7) == 0);
      b_wd = ($urandom_range(0, 7) == 0);
      #1;
      ch_step(mar, {6'd0, a_rr}, a_rd, 2, 4, nr, gr, br, abr);
      ch_step(maw, {6'd0, a_wr}, a_wd, 2, 4, nw, gw, bw, abw);
      chk("rA.rg", c, a_rg, gr[1:0]);
      chk("rA.wg", c, a_wg, gw[1:0]);
      chk("rA.busy", c, {a_rb, a_wb}, {br, bw});
      chk("rA.to", c, {a_rt, a_wt}, {ea_rt[0], ea_wt[0]});
      chk("rA.id", c, a_id, ea_id);
      ea_rt = abr; ea_wt = abw;
      if (abw) ea_id = maw.owner;
      else if (abr) ea_id = mar.owner;
      mar = nr; maw = nw;

      ch_step(mbr, {3'd0, b_rr}, b_rd, 5, 6, nr, gr, br, abr);
      ch_step(mbw, {3'd0, b_wr}, b_wd, 5, 6, nw, gw, bw, abw);
      chk("rB.rg", c, b_rg, gr[4:0]);
      chk("rB.wg", c, b_wg, gw[4:0]);
      chk("rB.busy", c, {b_rb, b_wb}, {br, bw});
      chk("rB.to", c, {b_rt, b_wt}, {eb_rt[0], eb_wt[0]});
      chk("rB.id", c, b_id, eb_id);
      eb_rt = abr; eb_wt = abw;
      if (abw) eb_id = mbw.owner;
      else if (abr) eb_id = mbr.owner;
      mbr = nr; mbw = nw;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
